// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side and memory-side signals around mem_arbiter.
// The master modport is the arbiter's view (it masters the memory port);
// the slave modport is the view of the caches and memory around it.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  // Data cache side
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;
  // Instruction cache side
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;
  // Main memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport master (
    input  d_read, d_write, d_address, d_writedata, i_read, i_address,
    input  mem_readdata, mem_busywait,
    output d_readdata, d_busywait, i_readdata, i_busywait,
    output mem_read, mem_write, mem_address, mem_writedata
  );

  modport slave (
    output d_read, d_write, d_address, d_writedata, i_read, i_address,
    output mem_readdata, mem_busywait,
    input  d_readdata, d_busywait, i_readdata, i_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one block-wide main memory port between icache and dcache.
// One transaction at a time; each cache is stalled by its own busywait.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of
// fixed dcache priority.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StDBusy,
    StIBusy,
    StDDone,
    StIDone
  } state_e;

  typedef enum logic {
    GrantI = 1'b0,
    GrantD = 1'b1
  } grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              issued_q, issued_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
  logic [DATA_W-1:0] d_readdata_q, d_readdata_d;
  logic [DATA_W-1:0] i_readdata_q, i_readdata_d;

  logic d_req;
  logic i_req;
  logic d_wins;

  assign d_req = bus_io.d_read | bus_io.d_write;
  assign i_req = bus_io.i_read;

  // Decide whether the dcache takes the port when arbitrating in idle
`ifdef ARB_ROUND_ROBIN_EN
  assign d_wins = d_req & (~i_req | (last_grant_q == GrantI));
`else
  assign d_wins = d_req;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    issued_d        = issued_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    d_readdata_d    = d_readdata_q;
    i_readdata_d    = i_readdata_q;

    case (state_q)
      StIdle: begin
        if (d_wins) begin
          state_d       = StDBusy;
          last_grant_d  = GrantD;
          issued_d      = 1'b0;
          mem_address_d = bus_io.d_address;
          // A write-back wins over a read when both are raised
          if (bus_io.d_write) begin
            mem_write_d     = 1'b1;
            mem_read_d      = 1'b0;
            mem_writedata_d = bus_io.d_writedata;
          end else begin
            mem_write_d = 1'b0;
            mem_read_d  = 1'b1;
          end
        end else if (i_req) begin
          state_d       = StIBusy;
          last_grant_d  = GrantI;
          issued_d      = 1'b0;
          mem_address_d = bus_io.i_address;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
        end
      end

      StDBusy, StIBusy: begin
        // First edge gives memory a cycle to see the strobe; busywait is ignored
        if (!issued_q) begin
          issued_d = 1'b1;
        end else if (!bus_io.mem_busywait) begin
          if (mem_read_q) begin
            if (state_q == StDBusy) begin
              d_readdata_d = bus_io.mem_readdata;
            end else begin
              i_readdata_d = bus_io.mem_readdata;
            end
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == StDBusy) begin
            state_d = StDDone;
          end else begin
            state_d = StIDone;
          end
        end
      end

      StDDone, StIDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= StIdle;
      last_grant_q    <= GrantI;
      issued_q        <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      d_readdata_q    <= '0;
      i_readdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      issued_q        <= issued_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      d_readdata_q    <= d_readdata_d;
      i_readdata_q    <= i_readdata_d;
    end
  end

  assign bus_io.mem_read      = mem_read_q;
  assign bus_io.mem_write     = mem_write_q;
  assign bus_io.mem_address   = mem_address_q;
  assign bus_io.mem_writedata = mem_writedata_q;
  assign bus_io.d_readdata    = d_readdata_q;
  assign bus_io.i_readdata    = i_readdata_q;

  // Stalls are combinational so each cache is released exactly in its done cycle
  assign bus_io.d_busywait = d_req & (state_q != StDDone);
  assign bus_io.i_busywait = i_req & (state_q != StIDone);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: randomized transactions against a
// transaction-level model (reference memory contents, 3+latency stall rule,
// tie-break rule). Build with +define+ARB_ROUND_ROBIN_EN for the round-robin variant.
module tb_mem_arbiter;
  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RrMode = 1'b1;
`else
  localparam bit RrMode = 1'b0;
`endif

  logic clock;
  logic reset;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus_io(bus)
  );

  int n_checks;
  int n_fail;
  bit exp_last_d;  // model of last grant: 1 = dcache
  int unsigned mem_lat = 0;
  int unsigned mem_cnt;
  logic [DW-1:0] phys_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [DW-1:0] init_pattern(input logic [AW-1:0] a);
    return {4{{4'h0, a} ^ 32'hC3C3_0000}};
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_pattern(a);
  endfunction

  function automatic logic [DW-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Tie rule: fixed priority favours dcache; round-robin favours the one not granted last
  function automatic bit pick_d_on_tie(input bit last_d);
    return RrMode ? !last_d : 1'b1;
  endfunction

  // Memory: busy for mem_lat cycles after the sample cycle; data is junk until ready
  initial begin
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    mem_cnt = 0;
    forever begin
      @(negedge clock);
      if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) mem_cnt++;
      else mem_cnt = 0;
      if (bus.mem_write === 1'b1) phys_mem[bus.mem_address] = bus.mem_writedata;
      bus.mem_busywait = (mem_cnt != 0) && (mem_cnt <= mem_lat + 1);
      if (bus.mem_read === 1'b1 && !bus.mem_busywait)
        bus.mem_readdata = phys_mem.exists(bus.mem_address) ? phys_mem[bus.mem_address]
                                                             : init_pattern(bus.mem_address);
      else
        bus.mem_readdata = rand128();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Counts cycles the selected busywait stays high; bounded
  task automatic wait_busy_low(input bit is_d, output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1'b0;
    #1;
    while ((is_d ? bus.d_busywait : bus.i_busywait) === 1'b1) begin
      if (cyc >= 100) begin
        timed_out = 1'b1;
        break;
      end
      cyc++;
      @(negedge clock); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.d_read = 1'b1;
    bus.d_address = AW'(28'h55);
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (bus.mem_read !== 1'b0) begin n_fail++;
      $display("FAIL reset_mem_read: got %b expected 0", bus.mem_read); end
    n_checks++; if (bus.mem_write !== 1'b0) begin n_fail++;
      $display("FAIL reset_mem_write: got %b expected 0", bus.mem_write); end
    n_checks++; if (bus.mem_address !== '0) begin n_fail++;
      $display("FAIL reset_mem_address: got %0h expected 0", bus.mem_address); end
    n_checks++; if (bus.mem_writedata !== '0) begin n_fail++;
      $display("FAIL reset_mem_writedata: got %0h expected 0", bus.mem_writedata); end
    n_checks++; if (bus.d_readdata !== '0 || bus.i_readdata !== '0) begin n_fail++;
      $display("FAIL reset_readdata: got %0h/%0h expected 0/0", bus.d_readdata, bus.i_readdata); end
    n_checks++; if (bus.d_busywait !== 1'b1) begin n_fail++;
      $display("FAIL reset_d_busywait: got %b expected 1", bus.d_busywait); end
    bus.d_read = 1'b0;
    reset = 1'b0;
    exp_last_d = 1'b0;
    @(negedge clock); #1;
    n_checks++; if (bus.d_busywait !== 1'b0 || bus.mem_read !== 1'b0) begin n_fail++;
      $display("FAIL reset_idle: got busy=%b rd=%b expected 0 0", bus.d_busywait, bus.mem_read); end
  endtask

  task automatic test_tie;
    logic [AW-1:0] da, ia;
    bit d_done, i_done, exp_d_first, got_d_first, overlap;
    int cyc;
    da = AW'($urandom_range(0, 15));
    ia = AW'($urandom_range(16, 31));
    exp_d_first = pick_d_on_tie(exp_last_d);
    mem_lat = $urandom_range(0, 3);
    bus.d_address = da; bus.i_address = ia;
    bus.d_write = 1'b0; bus.d_read = 1'b1; bus.i_read = 1'b1;
    d_done = 0; i_done = 0; overlap = 0; got_d_first = 0; cyc = 0;
    while (!(d_done && i_done) && cyc < 200) begin
      @(negedge clock); #1;
      cyc++;
      if (!d_done && !i_done && bus.d_busywait === 1'b0 && bus.i_busywait === 1'b0) overlap = 1;
      if (!d_done && bus.d_busywait === 1'b0) begin
        d_done = 1;
        if (!i_done) got_d_first = 1;
        n_checks++; if (bus.d_readdata !== ref_read(da)) begin n_fail++;
          $display("FAIL tie_d_data: got %0h expected %0h", bus.d_readdata, ref_read(da)); end
        bus.d_read = 1'b0;
      end
      if (!i_done && bus.i_busywait === 1'b0) begin
        i_done = 1;
        n_checks++; if (bus.i_readdata !== ref_read(ia)) begin n_fail++;
          $display("FAIL tie_i_data: got %0h expected %0h", bus.i_readdata, ref_read(ia)); end
        bus.i_read = 1'b0;
      end
    end
    n_checks++; if (!(d_done && i_done)) begin n_fail++;
      $display("FAIL tie_timeout: got done=%b%b expected 11", d_done, i_done); end
    n_checks++; if (got_d_first !== exp_d_first) begin n_fail++;
      $display("FAIL tie_order: got d_first=%b expected %b", got_d_first, exp_d_first); end
    n_checks++; if (overlap !== 1'b0) begin n_fail++;
      $display("FAIL tie_overlap: got %b expected 0", overlap); end
    exp_last_d = !exp_d_first;
    @(negedge clock); #1;
  endtask

  task automatic test_icache_read;
    logic [DW-1:0] pat;
    int cyc, scyc;
    bit bad_addr, wr_seen;
    pat = {16{8'hA5}};
    phys_mem[AW'(28'h10)] = pat;
    ref_mem[AW'(28'h10)] = pat;
    mem_lat = 3;
    bus.i_address = AW'(28'h10); bus.i_read = 1'b1;
    cyc = 0; scyc = 0; bad_addr = 0; wr_seen = 0;
    #1;
    while (bus.i_busywait === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clock); #1;
      if (bus.mem_write !== 1'b0) wr_seen = 1;
      if (bus.mem_read === 1'b1) begin
        scyc++;
        if (bus.mem_address !== AW'(28'h10)) bad_addr = 1;
      end
    end
    n_checks++; if (cyc != 6) begin n_fail++;
      $display("FAIL iread_stall: got %0d expected 6", cyc); end
    n_checks++; if (scyc != 5) begin n_fail++;
      $display("FAIL iread_strobe_cycles: got %0d expected 5", scyc); end
    n_checks++; if (bad_addr !== 1'b0) begin n_fail++;
      $display("FAIL iread_address: got unstable expected stable 10"); end
    n_checks++; if (bus.i_readdata !== pat) begin n_fail++;
      $display("FAIL iread_data: got %0h expected %0h", bus.i_readdata, pat); end
    bus.i_read = 1'b0;
    exp_last_d = 1'b0;
    @(negedge clock); #1;
    if (bus.mem_write !== 1'b0) wr_seen = 1;
    n_checks++; if (wr_seen !== 1'b0 || bus.mem_read !== 1'b0) begin n_fail++;
      $display("FAIL iread_idle: got wr_seen=%b rd=%b expected 0 0", wr_seen, bus.mem_read); end
  endtask

  task automatic test_dcache_write;
    logic [DW-1:0] wd, prev;
    int cyc, scyc;
    bit bad, rd_seen, to;
    wd = 128'h11223344556677889900AABBCCDDEEFF;
    prev = bus.d_readdata;
    mem_lat = 0;
    bus.d_address = AW'(28'h20); bus.d_writedata = wd; bus.d_read = 1'b0; bus.d_write = 1'b1;
    cyc = 0; scyc = 0; bad = 0; rd_seen = 0;
    #1;
    while (bus.d_busywait === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clock); #1;
      if (bus.mem_read !== 1'b0) rd_seen = 1;
      if (bus.mem_write === 1'b1) begin
        scyc++;
        if (bus.mem_address !== AW'(28'h20) || bus.mem_writedata !== wd) bad = 1;
      end
    end
    n_checks++; if (cyc != 3) begin n_fail++;
      $display("FAIL dwrite_stall: got %0d expected 3", cyc); end
    n_checks++; if (scyc != 2 || bad !== 1'b0 || rd_seen !== 1'b0) begin n_fail++;
      $display("FAIL dwrite_strobe: got cyc=%0d bad=%b rd=%b expected 2 0 0", scyc, bad, rd_seen); end
    n_checks++; if (bus.d_readdata !== prev) begin n_fail++;
      $display("FAIL dwrite_readdata_hold: got %0h expected %0h", bus.d_readdata, prev); end
    ref_mem[AW'(28'h20)] = wd;
    bus.d_write = 1'b0;
    @(negedge clock); #1;
    // Read the block back through the dcache
    mem_lat = $urandom_range(0, 3);
    bus.d_read = 1'b1;
    wait_busy_low(1'b1, cyc, to);
    n_checks++; if (to || bus.d_readdata !== ref_read(AW'(28'h20))) begin n_fail++;
      $display("FAIL dwrite_readback: got %0h expected %0h", bus.d_readdata, wd); end
    bus.d_read = 1'b0;
    exp_last_d = 1'b1;
    @(negedge clock); #1;
  endtask

  task automatic test_starvation;
    logic [AW-1:0] da, ia;
    bit prev_rd, got_d, exp_d;
    int grants, cyc;
    da = AW'(28'h100); ia = AW'(28'h200);
    mem_lat = 1;
    bus.d_address = da; bus.i_address = ia;
    bus.d_write = 1'b0; bus.d_read = 1'b1; bus.i_read = 1'b1;
    grants = 0; cyc = 0; prev_rd = 1'b0;
    while (grants < 6 && cyc < 300) begin
      @(negedge clock); #1;
      cyc++;
      if (bus.mem_read === 1'b1 && !prev_rd) begin
        got_d = (bus.mem_address === da);
        exp_d = pick_d_on_tie(exp_last_d);
        n_checks++; if (got_d !== exp_d) begin n_fail++;
          $display("FAIL starve_grant%0d: got d=%b expected d=%b", grants, got_d, exp_d); end
        exp_last_d = exp_d;
        grants++;
      end
      prev_rd = (bus.mem_read === 1'b1);
    end
    n_checks++; if (grants != 6) begin n_fail++;
      $display("FAIL starve_timeout: got %0d grants expected 6", grants); end
    bus.d_read = 1'b0; bus.i_read = 1'b0;
    cyc = 0;
    while (bus.mem_read === 1'b1 && cyc < 50) begin @(negedge clock); #1; cyc++; end
    @(negedge clock); #1;
    n_checks++; if (bus.mem_read !== 1'b0) begin n_fail++;
      $display("FAIL starve_drain: got %b expected 0", bus.mem_read); end
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] a;
    int cyc, lat;
    bit to;
    a = AW'(28'h300 + $urandom_range(0, 7));
    mem_lat = 3;
    bus.d_write = 1'b0; bus.d_address = a; bus.d_read = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    n_checks++; if (bus.mem_read !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_busy: got %b expected 1", bus.mem_read); end
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
    n_checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_strobes: got %b%b expected 00", bus.mem_read, bus.mem_write); end
    n_checks++; if (bus.mem_address !== '0 || bus.d_readdata !== '0) begin n_fail++;
      $display("FAIL rstmid_regs: got %0h/%0h expected 0/0", bus.mem_address, bus.d_readdata); end
    n_checks++; if (bus.d_busywait !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_no_done: got %b expected 1", bus.d_busywait); end
    bus.d_read = 1'b0;
    exp_last_d = 1'b0;
    @(negedge clock); #1;
    a = AW'($urandom_range(0, 7));
    lat = $urandom_range(0, 3);
    mem_lat = lat;
    bus.i_address = a; bus.i_read = 1'b1;
    wait_busy_low(1'b0, cyc, to);
    n_checks++; if (to || cyc != lat + 3) begin n_fail++;
      $display("FAIL rstmid_iread_stall: got %0d expected %0d", cyc, lat + 3); end
    n_checks++; if (bus.i_readdata !== ref_read(a)) begin n_fail++;
      $display("FAIL rstmid_iread_data: got %0h expected %0h", bus.i_readdata, ref_read(a)); end
    bus.i_read = 1'b0;
    @(negedge clock); #1;
  endtask

  task automatic test_drop_request;
    logic [AW-1:0] a;
    int cyc, scyc, lat;
    bit regrant;
    a = AW'($urandom_range(0, 7));
    lat = $urandom_range(0, 3);
    mem_lat = lat;
    bus.d_write = 1'b0; bus.d_address = a; bus.d_read = 1'b1;
    @(negedge clock); #1;
    n_checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== a) begin n_fail++;
      $display("FAIL drop_grant: got rd=%b addr=%0h expected 1 %0h", bus.mem_read,
               bus.mem_address, a); end
    bus.d_read = 1'b0;
    scyc = 1; cyc = 0;
    while (bus.mem_read === 1'b1 && cyc < 100) begin
      @(negedge clock); #1;
      cyc++;
      if (bus.mem_read === 1'b1) scyc++;
    end
    n_checks++; if (scyc != lat + 2) begin n_fail++;
      $display("FAIL drop_strobe_cycles: got %0d expected %0d", scyc, lat + 2); end
    n_checks++; if (bus.d_readdata !== ref_read(a) || bus.d_busywait !== 1'b0) begin n_fail++;
      $display("FAIL drop_done: got %0h busy=%b expected %0h 0", bus.d_readdata,
               bus.d_busywait, ref_read(a)); end
    regrant = 0;
    repeat (4) begin
      @(negedge clock); #1;
      if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) regrant = 1;
    end
    n_checks++; if (regrant !== 1'b0) begin n_fail++;
      $display("FAIL drop_regrant: got %b expected 0", regrant); end
    exp_last_d = 1'b1;
  endtask

  task automatic test_random;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, prev;
    bit is_d, is_wr, to;
    int cyc, lat;
    for (int n = 0; n < 24; n++) begin
      is_d = 1'($urandom_range(0, 1));
      is_wr = is_d && ($urandom_range(0, 2) == 0);
      a = AW'($urandom_range(0, 7));
      wd = rand128();
      lat = $urandom_range(0, 4);
      mem_lat = lat;
      prev = bus.d_readdata;
      if (is_d) begin
        bus.d_address = a; bus.d_writedata = wd; bus.d_write = is_wr;
        // Sometimes raise read alongside write: the write must win
        bus.d_read = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        bus.i_address = a; bus.i_read = 1'b1;
      end
      wait_busy_low(is_d, cyc, to);
      n_checks++; if (to || cyc != lat + 3) begin n_fail++;
        $display("FAIL rand%0d_stall: got %0d expected %0d", n, cyc, lat + 3); end
      n_checks++;
      if (is_wr) begin
        if (bus.d_readdata !== prev) begin n_fail++;
          $display("FAIL rand%0d_wr_hold: got %0h expected %0h", n, bus.d_readdata, prev); end
        ref_mem[a] = wd;
      end else if (is_d) begin
        if (bus.d_readdata !== ref_read(a)) begin n_fail++;
          $display("FAIL rand%0d_d_data: got %0h expected %0h", n, bus.d_readdata, ref_read(a)); end
      end else begin
        if (bus.i_readdata !== ref_read(a)) begin n_fail++;
          $display("FAIL rand%0d_i_data: got %0h expected %0h", n, bus.i_readdata, ref_read(a)); end
      end
      exp_last_d = is_d;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.i_read = 1'b0;
      @(negedge clock); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_last_d = 1'b0;
    reset = 1'b1;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0; bus.d_writedata = '0;
    bus.i_read = 1'b0; bus.i_address = '0;
    test_reset();
    test_tie();
    test_tie();
    test_icache_read();
    test_dcache_write();
    test_tie();
    test_starvation();
    test_reset_mid();
    test_drop_request();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit block-wide main memory port between the instruction cache and the data cache.
- Sits between both cache controllers and main memory.
- Runs at most one memory transaction at a time and returns the read block to the requester.
- Stalls each cache with its own busywait until that cache's transaction completes.

Parameters:
ADDR_W, 28, block-address width (word address bits [31:4])
DATA_W, 128, block width in bits

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
d_read  input  1  dcache block read request
d_write  input  1  dcache block write-back request
d_address  input  ADDR_W  dcache block address
d_writedata  input  DATA_W  dcache write-back block
d_readdata  output  DATA_W  block returned to dcache
d_busywait  output  1  stall to dcache
i_read  input  1  icache block read request
i_address  input  ADDR_W  icache block address
i_readdata  output  DATA_W  block returned to icache
i_busywait  output  1  stall to icache
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_address  output  ADDR_W  memory block address
mem_writedata  output  DATA_W  memory write block
mem_readdata  input  DATA_W  memory read block
mem_busywait  input  1  memory busy

Behaviour:
- Clocking: one clock domain; all state changes on the rising edge of clock.
- Reset: reset is synchronous, active-high. While reset is high at an edge:
  - state <= IDLE;
  - mem_read, mem_write <= 0;
  - mem_address, mem_writedata, d_readdata, i_readdata <= 0;
  - last_grant <= I.
  - Reset mid-transaction aborts it: strobes are low after that edge, and no DONE cycle occurs.
- States: IDLE, D_BUSY, I_BUSY, D_DONE, I_DONE. A 1-bit issued flag is cleared on entry to each BUSY state.
- Outputs are registered except busywaits:
  - d_busywait = (d_read | d_write) & (state != D_DONE)
  - i_busywait = i_read & (state != I_DONE)
- IDLE:
  - Arbitrates among pending requests (d_read|d_write, i_read).
  - Winner moves to D_BUSY or I_BUSY, and last_grant is updated.
  - On the same edge, latch address (and d_writedata for writes) into mem_address/mem_writedata.
  - Set mem_write if d_write, else set mem_read. d_write has precedence if d_read and d_write are both high.
  - With no request pending, stay in IDLE.
- D_BUSY / I_BUSY:
  - First edge in the state only sets issued (memory sample cycle); mem_busywait is ignored.
  - On a later edge with issued=1 and mem_busywait=0, the transaction completes:
    - capture mem_readdata into d_readdata or i_readdata (read only; on a write, d_readdata holds its value);
    - clear the strobes;
    - go to D_DONE or I_DONE.
  - Strobes and address stay stable throughout the BUSY state.
  - The transaction runs to completion even if the requester drops its request.
- D_DONE / I_DONE:
  - Exactly one cycle; the matching busywait is low and readdata is valid.
  - Next state is always IDLE.
  - A request still high in IDLE is treated as a new request.
- The non-granted requester keeps its busywait high for the whole transaction.
- Latency: request high before edge E0 → strobes high after E0.
  - With zero memory busy, completion at E2, DONE in cycle E2–E3, and a 3-cycle stall.
  - Each extra mem_busywait cycle adds one cycle.
- Simultaneous requests in IDLE are resolved by the priority rule (see Optional Feature).

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin. On a tie, the requester not equal to last_grant wins. Reset sets last_grant=I, so dcache wins the first tie.
- Undefined: fixed priority; dcache always wins ties. last_grant is still maintained but unused, so the icache can starve.

Test Plan:
- Single icache read, i_address=0x0000010, memory busy 3 cycles returning 0xA5A5…A5 → mem_read=1 with mem_address=0x0000010 for the whole busy period; i_readdata=0xA5A5…A5 during the one i_busywait-low cycle; back to IDLE; mem_write never asserted.
- Dcache write-back, d_address=0x0000020, d_writedata=0x1122…FF, zero memory busy → mem_write=1 with matching address/data; d_busywait low exactly at E2; d_readdata unchanged.
- d_read and i_read asserted in the same cycle, held high until each one's DONE:
  - undefined macro: dcache served first, icache second, i_busywait high throughout the dcache transaction;
  - with ARB_ROUND_ROBIN_EN: dcache first on the first tie; on the next tie, icache wins.
- Fixed priority with d_read continuously re-asserted after each DONE → icache is never granted while dcache keeps requesting; with ARB_ROUND_ROBIN_EN, grants alternate D, I, D, I.
- Reset asserted for 1 cycle mid-D_BUSY → strobes 0 and state IDLE after that edge, no DONE cycle; a fresh i_read afterwards completes normally.
- d_read dropped one cycle after grant → memory read still completes; D_DONE occurs once with d_busywait low; no new request follows.
